// File: rtl/leaf_net_bridge.sv
// Leaf-side network bridge: round-robin egress merge of user streams into routed flits,
// and ingress flit decode/steer into per-port first-word-fall-through FIFOs.
module leaf_net_bridge #(
  parameter int PAYLOAD_BITS = 32,
  parameter int PORT_NUM_IN  = 2,
  parameter int PORT_NUM_OUT = 2,
  parameter int LEAF_BITS    = 5,
  parameter int PORT_BITS    = 4,
  parameter int SELF_LEAF    = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [PAYLOAD_BITS*PORT_NUM_IN-1:0]         din,
  input  logic [PORT_NUM_IN-1:0]                      val_in,
  output logic [PORT_NUM_IN-1:0]                      ready_upward,
  output logic [PAYLOAD_BITS*PORT_NUM_OUT-1:0]        dout,
  output logic [PORT_NUM_OUT-1:0]                     val_out,
  input  logic [PORT_NUM_OUT-1:0]                     ready_downward,
  input  logic [LEAF_BITS+PORT_BITS+PAYLOAD_BITS-1:0] net_din,
  input  logic                                        net_val_in,
  output logic                                        net_ready_upward,
  output logic [LEAF_BITS+PORT_BITS+PAYLOAD_BITS-1:0] net_dout,
  output logic                                        net_val_out,
  input  logic                                        net_ready_downward,
  input  logic                                        cfg_wr,
  input  logic [PORT_BITS-1:0]                        cfg_idx,
  input  logic [LEAF_BITS+PORT_BITS-1:0]              cfg_data,
  output logic [15:0]                                 drop_cnt
);

  localparam int NET_BITS   = LEAF_BITS + PORT_BITS + PAYLOAD_BITS;
  localparam int ROUTE_BITS = LEAF_BITS + PORT_BITS;
  localparam int IN_IDX_W   = (PORT_NUM_IN > 1) ? $clog2(PORT_NUM_IN) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;

  // ---------------- Ingress ----------------
  logic [NET_BITS-1:0]     hold_reg;
  logic                    hold_v_reg;
  logic [15:0]             drop_cnt_reg;
  logic [LEAF_BITS-1:0]    hold_leaf;
  logic [PORT_BITS-1:0]    hold_port;
  logic                    hold_drop;
  logic                    hold_fire;
  logic                    full_sel;
  logic                    net_accept;
  logic [PORT_NUM_OUT-1:0] full;

  assign hold_leaf = hold_reg[NET_BITS-1 -: LEAF_BITS];
  assign hold_port = hold_reg[PAYLOAD_BITS +: PORT_BITS];
  assign hold_drop = (hold_leaf != LEAF_BITS'(SELF_LEAF)) || (int'(hold_port) >= PORT_NUM_OUT);

  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < PORT_NUM_OUT; i++) begin
      if (int'(hold_port) == i) full_sel = full[i];
    end
  end

  // Drops always retire in one cycle; a full destination blocks the whole ingress path.
  assign hold_fire        = hold_v_reg & (hold_drop | ~full_sel);
  assign net_ready_upward = ~reset & (~hold_v_reg | hold_fire);
  assign net_accept       = net_val_in & net_ready_upward;
  assign drop_cnt         = drop_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_reg     <= '0;
      hold_v_reg   <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (net_accept) begin
        hold_reg   <= net_din;
        hold_v_reg <= 1'b1;
      end else if (hold_fire) begin
        hold_v_reg <= 1'b0;
      end
      if (hold_fire && hold_drop && drop_cnt_reg != 16'hFFFF)
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PORT_NUM_OUT; gi++) begin : g_fifo
      logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]        wr_ptr_reg;
      logic [PTR_W-1:0]        rd_ptr_reg;
      logic [CNT_W-1:0]        count_reg;
      logic                    push;
      logic                    pop;

      // full uses the pre-pop count, so a simultaneous pop never frees a slot early
      assign full[gi] = (count_reg == CNT_W'(FIFO_DEPTH));
      assign push     = hold_fire & ~hold_drop & (int'(hold_port) == gi);
      assign pop      = (count_reg != '0) & ready_downward[gi];

      assign val_out[gi]                           = (count_reg != '0);
      assign dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem[rd_ptr_reg];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(push);
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop);
          count_reg  <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
      end

      always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= hold_reg[PAYLOAD_BITS-1:0];
      end
    end
  endgenerate

  // ---------------- Egress ----------------
  logic [ROUTE_BITS-1:0]   route_tbl [PORT_NUM_IN];
  logic [IN_IDX_W-1:0]     last_reg;
  logic [IN_IDX_W-1:0]     grant_idx;
  logic [PORT_NUM_IN-1:0]  grant;
  logic                    any_req;
  logic [PAYLOAD_BITS-1:0] din_sel;
  logic [ROUTE_BITS-1:0]   route_sel;
  logic [NET_BITS-1:0]     net_dout_reg;
  logic                    net_val_out_reg;
  logic                    load_en;

  always_comb begin : arb
    int cand;
    cand      = 0;
    any_req   = 1'b0;
    grant_idx = '0;
    grant     = '0;
    din_sel   = '0;
    route_sel = '0;
    // Rotating priority: search starts just after the last granted stream.
    for (int k = 0; k < PORT_NUM_IN; k++) begin
      cand = (int'(last_reg) + 1 + k) % PORT_NUM_IN;
      if (!any_req && val_in[cand]) begin
        any_req   = 1'b1;
        grant_idx = IN_IDX_W'(cand);
        din_sel   = din[cand*PAYLOAD_BITS +: PAYLOAD_BITS];
        route_sel = route_tbl[IN_IDX_W'(cand)];
      end
    end
    if (any_req) grant[grant_idx] = 1'b1;
  end

  assign load_en      = ~net_val_out_reg | net_ready_downward;
  assign ready_upward = (load_en & ~reset) ? grant : '0;
  assign net_dout     = net_dout_reg;
  assign net_val_out  = net_val_out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      net_dout_reg    <= '0;
      net_val_out_reg <= 1'b0;
      last_reg        <= '0;
      for (int i = 0; i < PORT_NUM_IN; i++) route_tbl[i] <= '0;
    end else begin
      if (load_en) begin
        if (any_req) begin
          net_dout_reg    <= {route_sel, din_sel};
          net_val_out_reg <= 1'b1;
          last_reg        <= grant_idx;
        end else begin
          net_val_out_reg <= 1'b0;
        end
      end
      // route_sel was read from the pre-write table, so a same-cycle grant sees the old entry
      if (cfg_wr && (int'(cfg_idx) < PORT_NUM_IN))
        route_tbl[IN_IDX_W'(cfg_idx)] <= cfg_data;
    end
  end

endmodule
